// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared definitions for the two-master system bus arbiter.
//   SB_ADR_W / SB_DAT_W : hard-IP system bus address and data widths
//   state_t             : arbiter FSM encoding (ST_IDLE / ST_XFER / ST_DONE)
package sysbus_pkg;

    localparam int SB_ADR_W = 8;
    localparam int SB_DAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sysbus_rr2.sv
// sysbus_rr2: combinational 2-way round-robin picker.
//   reqs       in  2  request lines, bit i = master i
//   last_grant in  1  index of the master served most recently
//   grant      out 1  index of the winning master (meaningful when valid)
//   valid      out 1  at least one request is present
module sysbus_rr2 (
    input  logic [1:0] reqs,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |reqs;
        grant = 1'b0;
        case (reqs)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // Contention: whoever was not served last time goes first.
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: two-master round-robin arbiter for the iCE40 hard-IP
// system bus. One transfer per grant, all bus-side and ack outputs registered.
// Optional feature macro: SBARB_TIMEOUT_EN (forced completion after TIMEOUT
// XFER cycles without sb_ack, sticky to_err flag cleared by to_clr).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m0_stb/we/adr/dati -> m0_ack/dato   master 0 request / completion
//   m1_stb/we/adr/dati -> m1_ack/dato   master 1 request / completion
//   sb_stb/rw/adr/dato -> sb_ack/dati   hard-IP system bus
//   busy                            transfer in progress (state != IDLE)
//   to_err, to_clr                  sticky timeout flag and its clear
// Handshake: a master holds mX_stb (and its qualifiers) high until it sees
// mX_ack, a single-cycle pulse; mX_dato is valid with the ack and held until
// that master's next completion. On the bus side sb_stb is held with stable
// sb_rw/sb_adr/sb_dato until sb_ack is sampled high.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int                  TIMEOUT = 255,
    parameter logic [SB_DAT_W-1:0] TO_DATA = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_stb,
    input  logic                m0_we,
    input  logic [SB_ADR_W-1:0] m0_adr,
    input  logic [SB_DAT_W-1:0] m0_dati,
    output logic                m0_ack,
    output logic [SB_DAT_W-1:0] m0_dato,
    input  logic                m1_stb,
    input  logic                m1_we,
    input  logic [SB_ADR_W-1:0] m1_adr,
    input  logic [SB_DAT_W-1:0] m1_dati,
    output logic                m1_ack,
    output logic [SB_DAT_W-1:0] m1_dato,
    output logic                sb_stb,
    output logic                sb_rw,
    output logic [SB_ADR_W-1:0] sb_adr,
    output logic [SB_DAT_W-1:0] sb_dato,
    input  logic                sb_ack,
    input  logic [SB_DAT_W-1:0] sb_dati,
    output logic                busy,
    output logic                to_err,
    input  logic                to_clr
);

    state_t              state, state_nxt;
    logic                grant, grant_nxt;
    logic                last_grant, last_grant_nxt;
    logic                sb_stb_nxt, sb_rw_nxt;
    logic [SB_ADR_W-1:0] sb_adr_nxt;
    logic [SB_DAT_W-1:0] sb_dato_nxt;
    logic                m0_ack_nxt, m1_ack_nxt;
    logic [SB_DAT_W-1:0] m0_dato_nxt, m1_dato_nxt;
    logic                to_err_nxt;
    logic                fin;
    logic [SB_DAT_W-1:0] rdata;
    logic                pick, pick_valid;

`ifdef SBARB_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
`else
    logic unused_cfg;
    assign unused_cfg = ^{to_clr, TO_DATA, TIMEOUT[0]};
`endif

    sysbus_rr2 u_rr2 (
        .reqs       ({m1_stb, m0_stb}),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        sb_stb_nxt     = sb_stb;
        sb_rw_nxt      = sb_rw;
        sb_adr_nxt     = sb_adr;
        sb_dato_nxt    = sb_dato;
        m0_ack_nxt     = 1'b0;
        m1_ack_nxt     = 1'b0;
        m0_dato_nxt    = m0_dato;
        m1_dato_nxt    = m1_dato;
        fin            = 1'b0;
        rdata          = sb_dati;
`ifdef SBARB_TIMEOUT_EN
        to_cnt_nxt     = to_cnt;
        to_err_nxt     = to_err & ~to_clr;
`else
        to_err_nxt     = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt   = ST_XFER;
                    grant_nxt   = pick;
                    sb_stb_nxt  = 1'b1;
                    sb_rw_nxt   = pick ? m1_we   : m0_we;
                    sb_adr_nxt  = pick ? m1_adr  : m0_adr;
                    sb_dato_nxt = pick ? m1_dati : m0_dati;
`ifdef SBARB_TIMEOUT_EN
                    to_cnt_nxt  = '0;
`endif
                end
            end
            ST_XFER: begin
                fin = sb_ack;
`ifdef SBARB_TIMEOUT_EN
                // A real ack on the terminal-count cycle is a normal completion.
                if (!sb_ack) begin
                    if (to_cnt == TO_LAST) begin
                        fin        = 1'b1;
                        rdata      = TO_DATA;
                        to_err_nxt = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt + 1'b1;
                    end
                end
`endif
                if (fin) begin
                    state_nxt      = ST_DONE;
                    sb_stb_nxt     = 1'b0;
                    last_grant_nxt = grant;
                    if (grant) m1_ack_nxt = 1'b1;
                    else       m0_ack_nxt = 1'b1;
                    // Writes leave the requester's read-data register alone.
                    if (!sb_rw) begin
                        if (grant) m1_dato_nxt = rdata;
                        else       m0_dato_nxt = rdata;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt  = ST_IDLE;
                sb_stb_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            sb_stb     <= 1'b0;
            sb_rw      <= 1'b0;
            sb_adr     <= '0;
            sb_dato    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_dato    <= '0;
            m1_dato    <= '0;
            to_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            sb_stb     <= sb_stb_nxt;
            sb_rw      <= sb_rw_nxt;
            sb_adr     <= sb_adr_nxt;
            sb_dato    <= sb_dato_nxt;
            m0_ack     <= m0_ack_nxt;
            m1_ack     <= m1_ack_nxt;
            m0_dato    <= m0_dato_nxt;
            m1_dato    <= m1_dato_nxt;
            to_err     <= to_err_nxt;
        end
    end

`ifdef SBARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt <= '0;
        else        to_cnt <= to_cnt_nxt;
    end
`endif

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: scoreboard bench for sysbus_arbiter. Directed requests
// push expected bus commands and expected master completions into queues;
// two monitors pop and compare whenever the DUT starts a bus transfer or
// pulses an ack. Build with +define+SBARB_TIMEOUT_EN to add the timeout case.
module tb_sysbus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m0_stb = 0, m0_we = 0, m1_stb = 0, m1_we = 0;
    logic [7:0] m0_adr = 0, m0_dati = 0, m1_adr = 0, m1_dati = 0;
    logic       m0_ack, m1_ack, sb_stb, sb_rw, sb_ack, busy, to_err;
    logic [7:0] m0_dato, m1_dato, sb_adr, sb_dato;
    logic [7:0] sb_dati = 8'h00;
    logic       to_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    // slave model controls
    int   slave_wait = 0;
    logic spur = 1'b0;
    logic ack_r;
    int   scnt;

    // scoreboard
    logic [16:0] exp_sb_q[$];   // {rw, adr, dat}
    logic [8:0]  exp_ack_q[$];  // {master, dato}
    logic [7:0]  dato_model[2];

    // monitor state
    logic        prev_stb = 1'b0;
    logic [16:0] cur_cmd;
    logic        gap_chk = 1'b0;
    logic        seen_fall = 1'b0;
    int          gap = 0;

    sysbus_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dati(m0_dati),
        .m0_ack(m0_ack), .m0_dato(m0_dato),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dati(m1_dati),
        .m1_ack(m1_ack), .m1_dato(m1_dato),
        .sb_stb(sb_stb), .sb_rw(sb_rw), .sb_adr(sb_adr), .sb_dato(sb_dato),
        .sb_ack(sb_ack), .sb_dati(sb_dati),
        .busy(busy), .to_err(to_err), .to_clr(to_clr)
    );

    // clock
    always #5 clk = ~clk;

    // registered slave: acks slave_wait cycles after first seeing sb_stb
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            scnt  <= 0;
        end else if (sb_stb && !ack_r) begin
            if (scnt >= slave_wait) begin
                ack_r <= 1'b1;
                scnt  <= 0;
            end else begin
                scnt <= scnt + 1;
            end
        end else begin
            ack_r <= 1'b0;
            scnt  <= 0;
        end
    end
    assign sb_ack = ack_r | spur;

    // bus-side monitor
    always @(negedge clk) begin
        if (rst_n && sb_stb && !prev_stb) begin
            checks++;
            if (exp_sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_cmd unexpected: got %h", {sb_rw, sb_adr, sb_dato});
            end else begin
                cur_cmd = exp_sb_q.pop_front();
                if ({sb_rw, sb_adr, sb_dato} !== cur_cmd) begin
                    failures++;
                    $display("FAIL sb_cmd got %h exp %h", {sb_rw, sb_adr, sb_dato}, cur_cmd);
                end
            end
            if (gap_chk && seen_fall) begin
                checks++;
                if (gap != 2) begin
                    failures++;
                    $display("FAIL sb_gap got %0d exp 2", gap);
                end
            end
        end else if (rst_n && sb_stb) begin
            checks++;
            if ({sb_rw, sb_adr, sb_dato} !== cur_cmd) begin
                failures++;
                $display("FAIL sb_stable got %h exp %h", {sb_rw, sb_adr, sb_dato}, cur_cmd);
            end
        end
        if (!sb_stb && prev_stb) begin
            seen_fall = 1'b1;
            gap = 1;
        end else if (!sb_stb) begin
            gap++;
        end
        prev_stb = sb_stb;
    end

    // completion monitor
    always @(negedge clk) begin
        if (m0_ack || m1_ack) begin
            checks++;
            if (m0_ack && m1_ack) begin
                failures++;
                $display("FAIL ack_both got m0_ack=1 m1_ack=1 exp one");
            end else if (exp_ack_q.size() == 0) begin
                failures++;
                $display("FAIL ack_unexpected got m0=%b m1=%b exp none", m0_ack, m1_ack);
            end else begin
                automatic logic [8:0] e = exp_ack_q.pop_front();
                automatic logic [8:0] g = {m1_ack, m1_ack ? m1_dato : m0_dato};
                if (g !== e) begin
                    failures++;
                    $display("FAIL ack got {m,dato}=%h exp %h", g, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic expect_xfer(input bit m, input logic we, input logic [7:0] adr,
                               input logic [7:0] dat, input logic [7:0] rdat);
        exp_sb_q.push_back({we, adr, dat});
        if (!we) dato_model[m] = rdat;
        exp_ack_q.push_back({m, dato_model[m]});
    endtask

    // single transfer, returns negedges from stb rise to ack seen
    task automatic xfer(input bit m, input logic we, input logic [7:0] adr, input logic [7:0] dat,
                        input int wt, input logic [7:0] rdat, output int lat);
        bit got;
        slave_wait = wt;
        sb_dati    = rdat;
        expect_xfer(m, we, adr, dat, rdat);
        @(negedge clk);
        if (m) begin m1_stb = 1; m1_we = we; m1_adr = adr; m1_dati = dat; end
        else   begin m0_stb = 1; m0_we = we; m0_adr = adr; m0_dati = dat; end
        lat = 0;
        got = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (m ? m1_ack : m0_ack) got = 1;
        end
        if (m) m1_stb = 0; else m0_stb = 0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout master %0d got no ack exp ack", m);
        end
    endtask

    initial begin
        int lat, c0, c1, n;
        dato_model[0] = 8'h00;
        dato_model[1] = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_bus", {sb_stb, sb_rw, sb_adr, sb_dato}, 32'h0);
        check("rst_ack", {busy, m0_ack, m1_ack, to_err}, 32'h0);
        check("rst_dato", {m0_dato, m1_dato}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // m0 write, zero-wait slave: ack 3 clk after stb
        xfer(0, 1, 8'h09, 8'h5A, 0, 8'h00, lat);
        check("m0_wr_latency", lat, 3);
        @(negedge clk);
        check("ack_one_cycle", {m0_ack, m1_ack, busy}, 32'h0);

        // m1 read with 4 wait cycles
        xfer(1, 0, 8'h0C, 8'h00, 4, 8'hA5, lat);
        check("m1_dato", m1_dato, 8'hA5);
        check("m0_dato_untouched", m0_dato, 8'h00);
        repeat (2) @(negedge clk);

        // both masters held for 4 transfers: m0,m1,m0,m1
        slave_wait = 0;
        sb_dati    = 8'h77;
        expect_xfer(0, 1, 8'h10, 8'h11, 8'h00);
        expect_xfer(1, 0, 8'h20, 8'h00, 8'h77);
        expect_xfer(0, 1, 8'h10, 8'h11, 8'h00);
        expect_xfer(1, 0, 8'h20, 8'h00, 8'h77);
        seen_fall = 1'b0;
        gap_chk   = 1'b1;
        @(negedge clk);
        m0_stb = 1; m0_we = 1; m0_adr = 8'h10; m0_dati = 8'h11;
        m1_stb = 1; m1_we = 0; m1_adr = 8'h20; m1_dati = 8'h00;
        c0 = 0; c1 = 0; n = 0;
        while ((c0 < 2 || c1 < 2) && n < 100) begin
            @(negedge clk);
            n++;
            if (m0_ack) begin c0++; if (c0 == 2) m0_stb = 0; end
            if (m1_ack) begin c1++; if (c1 == 2) m1_stb = 0; end
        end
        m0_stb = 0;
        m1_stb = 0;
        gap_chk = 1'b0;
        check("rr_ack_counts", {c0[15:0], c1[15:0]}, {16'd2, 16'd2});
        repeat (3) @(negedge clk);

        // async reset during XFER
        slave_wait = 1000;
        exp_sb_q.push_back({1'b0, 8'h33, 8'h00});
        @(negedge clk);
        m1_stb = 1; m1_we = 0; m1_adr = 8'h33; m1_dati = 8'h00;
        repeat (3) @(negedge clk);
        check("xfer_in_progress", {busy, sb_stb}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_sb_stb", {sb_stb, busy, m0_ack, m1_ack}, 32'h0);
        m1_stb = 0;
        dato_model[0] = 8'h00;
        dato_model[1] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slave_wait = 0;
        @(negedge clk);
        xfer(1, 0, 8'h44, 8'h00, 0, 8'h5C, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_dato", m1_dato, 8'h5C);

        // spurious sb_ack in IDLE, then read / write / read on m0
        repeat (2) @(negedge clk);
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spur_no_ack", {m0_ack, m1_ack, busy, sb_stb}, 32'h0);
        end
        spur = 1'b0;
        @(negedge clk);
        xfer(0, 0, 8'h30, 8'h00, 1, 8'h3C, lat);
        xfer(0, 1, 8'h31, 8'h99, 2, 8'hEE, lat);
        check("wr_keeps_dato", m0_dato, 8'h3C);
        xfer(0, 0, 8'h32, 8'h00, 0, 8'hC3, lat);
        check("rd_after_wr", m0_dato, 8'hC3);

`ifdef SBARB_TIMEOUT_EN
        // slave never acks: forced completion after 16 XFER cycles
        repeat (2) @(negedge clk);
        xfer(0, 0, 8'h40, 8'h00, 1000, 8'h12, lat);
        check("to_latency", lat, 17);
        check("to_dato", m0_dato, 8'hFF);
        check("to_err_set", to_err, 1'b1);
        @(negedge clk);
        to_clr = 1'b1;
        @(negedge clk);
        to_clr = 1'b0;
        check("to_err_clr", to_err, 1'b0);
`else
        check("to_err_tied", to_err, 1'b0);
`endif

        // drain
        repeat (5) @(negedge clk);
        check("sb_q_empty", exp_sb_q.size(), 0);
        check("ack_q_empty", exp_ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // timeout model for the expected queue in the forced-completion case
`ifdef SBARB_TIMEOUT_EN
    initial begin
        wait (exp_sb_q.size() > 0 && exp_sb_q[0] == {1'b0, 8'h40, 8'h00});
        // The read times out, so the completion returns the fill value.
        exp_ack_q[exp_ack_q.size()-1] = {1'b0, 8'hFF};
        dato_model[0] = 8'hFF;
    end
`endif

    // global guard
    initial begin
        #200000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1, "bench stalled");
    end

endmodule
